wb_stage: RTL and testbench

MEM/WB pipeline register plus the write-back stage and the 32×32 general register file of the pipeline CPU. It captures the data-memory read data and the ALU result, along with the destination and control bits, at the end of the MEM stage. It selects the write-back value and commits it to the register file. It also serves the two ID-stage read ports with write-through bypass, and counts retired instructions.

---
 rtl/wb_stage.sv | 94 +++++++++
 tb/tb_wb_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, write-back select, 32-entry register file with
// write-through read bypass for the ID stage, and a retired-instruction counter.
module wb_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  input  logic [DW-1:0] mem_dataout,
  input  logic [DW-1:0] mem_alu,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_wreg,
  input  logic          mem_m2reg,
  input  logic          stall,
  input  logic          flush,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic [AW-1:0] wb_rd,
  output logic          wb_wen,
  output logic [DW-1:0] wb_data,
  output logic [31:0]   retire_cnt
);

  localparam int NREG = 1 << AW;

  // Handshake: mem_valid marks a real instruction in MEM; stall holds the
  // WB entry (no commit, no reload); flush loads a bubble, and takes
  // priority over stall, while the older WB entry still commits unless stalled.
  logic          v_q;
  logic          wreg_q;
  logic          m2reg_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] mdata_q;
  logic [DW-1:0] alu_q;
  logic [31:0]   cnt_q;
  logic [DW-1:0] regs [NREG];
  logic          commit;
  logic          bypass_a;
  logic          bypass_b;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      v_q     <= 1'b0;
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      rd_q    <= '0;
      mdata_q <= '0;
      alu_q   <= '0;
    end else if (!stall) begin
      v_q     <= mem_valid;
      wreg_q  <= mem_wreg;
      m2reg_q <= mem_m2reg;
      rd_q    <= mem_rd;
      mdata_q <= mem_dataout;
      alu_q   <= mem_alu;
    end
  end

  assign wb_data = m2reg_q ? mdata_q : alu_q;
  assign wb_wen  = v_q & wreg_q & (rd_q != '0);
  assign wb_rd   = rd_q;
  assign commit  = rst_n & ~stall & v_q;

  // An entry writes exactly once, at the edge it leaves WB; wb_wen never
  // targets r0, so r0 stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit && wb_wen) begin
      regs[rd_q] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else if (commit) cnt_q <= cnt_q + 32'd1;
  end

  assign retire_cnt = cnt_q;

  assign bypass_a = wb_wen & ~stall & (rs == rd_q);
  assign bypass_b = wb_wen & ~stall & (rt == rd_q);

  always_comb begin
    qa = '0;
    qb = '0;
    if (rs != '0) qa = bypass_a ? wb_data : regs[rs];
    if (rt != '0) qb = bypass_b ? wb_data : regs[rt];
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: instruction-level reference model feeding an expected
// queue, a monitor comparing every cycle, directed corner cases and random traffic.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [31:0] mem_dataout;
  logic [31:0] mem_alu;
  logic [4:0]  mem_rd;
  logic        mem_wreg;
  logic        mem_m2reg;
  logic        stall;
  logic        flush;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] qa;
  logic [31:0] qb;
  logic [4:0]  wb_rd;
  logic        wb_wen;
  logic [31:0] wb_data;
  logic [31:0] retire_cnt;

  wb_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_dataout(mem_dataout),
    .mem_alu(mem_alu), .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .stall(stall), .flush(flush), .rs(rs), .rt(rt), .qa(qa), .qb(qb),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data), .retire_cnt(retire_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic [31:0] cnt;
    logic [31:0] qa;
    logic [31:0] qb;
  } obs_t;

  logic [$bits(obs_t)-1:0] exp_q[$];

  int checks = 0;
  int passes = 0;
  bit running = 0;
  bit preload = 0;

  // Reference model: the instruction sitting in WB, the architectural
  // register contents and the number of retired instructions.
  logic        m_v;
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [31:0] model_read(logic [4:0] a, logic stl);
    if (a == 5'd0) return 32'd0;
    if (m_wen && !stl && a == m_rd) return m_data;
    return m_regs[a];
  endfunction

  function automatic void model_clear();
    m_v = 0; m_wen = 0; m_rd = '0; m_data = '0;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic rstn, input logic valid, input logic [31:0] dout,
                       input logic [31:0] alu, input logic [4:0] rd, input logic wreg,
                       input logic m2reg, input logic stl, input logic fl,
                       input logic [4:0] a, input logic [4:0] b);
    obs_t o;
    @(negedge clk);
    if (preload) begin
      dut.cnt_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      preload = 0;
    end
    rst_n = rstn; mem_valid = valid; mem_dataout = dout; mem_alu = alu;
    mem_rd = rd; mem_wreg = wreg; mem_m2reg = m2reg; stall = stl; flush = fl;
    rs = a; rt = b;
    o.rd = m_rd; o.wen = m_wen; o.data = m_data; o.cnt = m_cnt;
    o.qa = model_read(a, stl); o.qb = model_read(b, stl);
    exp_q.push_back(o);
    if (!rstn) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = '0;
      model_clear();
    end else begin
      if (!stl && m_v) begin
        m_cnt = m_cnt + 32'd1;
        if (m_wen) m_regs[m_rd] = m_data;
      end
      if (fl) model_clear();
      else if (!stl) begin
        m_v = valid; m_rd = rd; m_data = m2reg ? dout : alu;
        m_wen = valid && wreg && (rd != 5'd0);
      end
    end
  endtask

  task automatic inst(input logic [31:0] alu, input logic [4:0] rd);
    drive(1, 1, 32'hDEAD_0000, alu, rd, 1, 0, 0, 0, 5'd0, 5'd0);
  endtask

  task automatic bub(input logic [4:0] a, input logic [4:0] b);
    drive(1, 0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, a, b);
  endtask

  task automatic settle();
    #3;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    obs_t o;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        o = exp_q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, o.rd});
        chk("wb_wen", {31'd0, wb_wen}, {31'd0, o.wen});
        chk("wb_data", wb_data, o.data);
        chk("retire_cnt", retire_cnt, o.cnt);
        chk("qa", qa, o.qa);
        chk("qb", qb, o.qb);
      end else if (running) begin
        checks++;
        $display("FAIL missing_expect: got empty queue expected an entry at %0t", $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] last_rd;
    logic [4:0] r;
    rst_n = 0; mem_valid = 0; mem_dataout = '0; mem_alu = '0; mem_rd = '0;
    mem_wreg = 0; mem_m2reg = 0; stall = 0; flush = 0; rs = '0; rt = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cnt = '0;
    model_clear();
    repeat (2) @(posedge clk);
    running = 1;

    // ALU write-back, bypass then register-file read
    inst(32'h1234, 5'd3);
    bub(5'd3, 5'd0); settle();
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_wen", {31'd0, wb_wen}, 32'd1);
    chk("alu_bypass_qa", qa, 32'h1234);
    bub(5'd3, 5'd0); settle();
    chk("alu_reg_qa", qa, 32'h1234);
    chk("alu_retire", retire_cnt, 32'd1);

    // load write-back selects memory data
    drive(1, 1, 32'h5, 32'h20, 5'd9, 1, 1, 0, 0, 5'd0, 5'd0);
    bub(5'd0, 5'd0);
    bub(5'd9, 5'd0); settle();
    chk("load_qa", qa, 32'h5);
    chk("load_retire", retire_cnt, 32'd2);

    // r0 is never written but the instruction still retires
    inst(32'hFFFF, 5'd0);
    bub(5'd0, 5'd0); settle();
    chk("r0_wen", {31'd0, wb_wen}, 32'd0);
    chk("r0_qa", qa, 32'd0);
    bub(5'd0, 5'd0); settle();
    chk("r0_retire", retire_cnt, 32'd3);

    // stall holds WB for three cycles, then a single commit
    inst(32'hAA, 5'd4);
    repeat (3) begin
      drive(1, 1, 32'd0, 32'h55, 5'd5, 1, 0, 1, 0, 5'd4, 5'd5);
      settle();
      chk("stall_qa", qa, 32'd0);
      chk("stall_retire", retire_cnt, 32'd3);
    end
    bub(5'd4, 5'd0); settle();
    chk("unstall_bypass", qa, 32'hAA);
    bub(5'd4, 5'd5); settle();
    chk("unstall_retire", retire_cnt, 32'd4);
    chk("unstall_qa", qa, 32'hAA);
    chk("stalled_input_dropped", qb, 32'd0);

    // flush: older WB entry commits, flushed instruction never writes
    inst(32'h66, 5'd6);
    drive(1, 1, 32'd0, 32'h77, 5'd7, 1, 0, 0, 1, 5'd0, 5'd0);
    bub(5'd6, 5'd7); settle();
    chk("flush_older_qa", qa, 32'h66);
    chk("flush_young_qb", qb, 32'd0);
    chk("flush_retire", retire_cnt, 32'd5);

    // stall and flush together: no commit, entry discarded
    inst(32'h88, 5'd8);
    drive(1, 1, 32'd0, 32'hAB, 5'd10, 1, 0, 1, 1, 5'd0, 5'd0);
    bub(5'd8, 5'd10); settle();
    chk("both_qa", qa, 32'd0);
    chk("both_qb", qb, 32'd0);
    chk("both_retire", retire_cnt, 32'd5);

    // back-to-back writes to the same register
    inst(32'h111, 5'd12);
    inst(32'h222, 5'd12);
    bub(5'd12, 5'd0); settle();
    chk("b2b_bypass", qa, 32'h222);
    bub(5'd12, 5'd0); settle();
    chk("b2b_reg", qa, 32'h222);
    chk("b2b_retire", retire_cnt, 32'd7);

    // reset mid-operation discards WB and clears everything
    inst(32'h1, 5'd11);
    drive(0, 0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 5'd7, 5'd0);
    bub(5'd3, 5'd11); settle();
    chk("rst_qa", qa, 32'd0);
    chk("rst_qb", qb, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    bub(5'd7, 5'd0); settle();
    chk("rst_r7", qa, 32'd0);

    // counter wrap through a preloaded count
    preload = 1;
    inst(32'hC, 5'd1);
    bub(5'd0, 5'd0); settle();
    chk("wrap_before", retire_cnt, 32'hFFFF_FFFF);
    bub(5'd1, 5'd0); settle();
    chk("wrap_after", retire_cnt, 32'd0);
    chk("wrap_qa", qa, 32'hC);

    // random traffic against the model
    last_rd = 5'd1;
    for (int n = 0; n < 600; n++) begin
      r = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
            r, ($urandom_range(0, 4) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) == 0) ? last_rd : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? last_rd : 5'($urandom_range(0, 31)));
      last_rd = r;
    end

    running = 0;
    repeat (3) @(negedge clk);
    #4;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
